// File: rtl/seq_scan_ctrl.sv
// Sequencer for an external serial seq_detector: clears it, streams a parallel word
// MSB-first into det_x, and gathers latency-compensated det_z samples into match statistics.
module seq_scan_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DET_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       busy,
  output logic                       done,
  output logic                       det_reset,
  output logic                       det_x,
  input  logic                       det_z,
  output logic [$clog2(WIDTH+1)-1:0] match_count,
  output logic                       found,
  output logic [$clog2(WIDTH)-1:0]   first_pos
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH-1);
  localparam logic [1:0]       LAST_DRAIN = 2'(DET_LAT-1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [1:0]         drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               det_x_q, det_x_d;

  logic               shift_vld;
  logic               samp_vld;
  logic [IDX_W-1:0]   samp_idx;

  assign shift_vld = (state_q == ST_SHIFT);

  // (valid, index) travel alongside the detector's latency so each det_z sample
  // is attributed to the bit that produced it.
  generate
    if (DET_LAT == 0) begin : g_comb
      assign samp_vld = shift_vld;
      assign samp_idx = bit_idx_q;
    end else begin : g_pipe
      logic [DET_LAT-1:0]            vld_pipe_q, vld_pipe_d;
      logic [DET_LAT-1:0][IDX_W-1:0] idx_pipe_q, idx_pipe_d;

      always_comb begin
        vld_pipe_d    = vld_pipe_q << 1;
        vld_pipe_d[0] = shift_vld;
        idx_pipe_d[0] = bit_idx_q;
        for (int unsigned i = 1; i < DET_LAT; i++) begin
          idx_pipe_d[i] = idx_pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_pipe_q <= '0;
          idx_pipe_q <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          idx_pipe_q <= idx_pipe_d;
        end
      end

      assign samp_vld = vld_pipe_q[DET_LAT-1];
      assign samp_idx = idx_pipe_q[DET_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    first_d   = first_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = '0;
          found_d = 1'b0;
          first_d = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        bit_idx_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_idx_q == LAST_IDX) begin
          drain_d = '0;
          state_d = (DET_LAT > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          shreg_d   = shreg_q << 1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (samp_vld && det_z) begin
      cnt_d = cnt_q + 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        first_d = samp_idx;
      end
    end

    // Outputs are registered from the next state; the shift register is
    // consumed from its MSB, which equals data_in[WIDTH-1-bit_idx].
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    det_x_d = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      drain_q   <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_x_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      det_x_q   <= det_x_d;
    end
  end

  assign det_reset   = reset | (state_q == ST_CLR);
  assign busy        = busy_q;
  assign done        = done_q;
  assign det_x       = det_x_q;
  assign match_count = cnt_q;
  assign found       = found_q;
  assign first_pos   = first_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench: two controllers (DET_LAT=0 with a Mealy 0110 detector, DET_LAT=1
// with a Moore one) share stimulus; a string-search reference predicts every scan.
module tb_seq_scan_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [3:0] mc;
    logic       found;
    logic [2:0] fp;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] din = '0;

  logic [1:0]      busy_w, done_w, dr_w, dx_w, dz_w, found_w;
  logic [1:0][3:0] mc_w;
  logic [1:0][2:0] fp_w;

  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;
  int   la [2];
  int   nf [2];
  logic [W-1:0] ld [2];
  res_t held [2];
  res_t q0 [$];
  res_t q1 [$];

  logic [3:0] hist [2];
  int         hcnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_scan_ctrl #(.WIDTH(W), .DET_LAT(0)) dut0 (
    .clk(clk), .reset(rst), .start(start), .data_in(din),
    .busy(busy_w[0]), .done(done_w[0]), .det_reset(dr_w[0]), .det_x(dx_w[0]),
    .det_z(dz_w[0]), .match_count(mc_w[0]), .found(found_w[0]), .first_pos(fp_w[0])
  );

  seq_scan_ctrl #(.WIDTH(W), .DET_LAT(1)) dut1 (
    .clk(clk), .reset(rst), .start(start), .data_in(din),
    .busy(busy_w[1]), .done(done_w[1]), .det_reset(dr_w[1]), .det_x(dx_w[1]),
    .det_z(dz_w[1]), .match_count(mc_w[1]), .found(found_w[1]), .first_pos(fp_w[1])
  );

  // Overlapping 0110 detectors; hcnt guards against matching on pre-clear zeros.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dr_w[k]) begin
        hist[k] <= '0;
        hcnt[k] <= 0;
      end else begin
        hist[k] <= {hist[k][2:0], dx_w[k]};
        hcnt[k] <= (hcnt[k] < 4) ? hcnt[k] + 1 : hcnt[k];
      end
    end
  end

  assign dz_w[0] = (hcnt[0] >= 3) && ({hist[0][2:0], dx_w[0]} == 4'b0110);
  assign dz_w[1] = (hcnt[1] >= 4) && (hist[1] == 4'b0110);

  function automatic res_t ref_scan(input logic [W-1:0] d);
    res_t r;
    logic [3:0] win;
    r = '0;
    for (int i = 3; i < W; i++) begin
      win = {d[W-1-(i-3)], d[W-1-(i-2)], d[W-1-(i-1)], d[W-1-i]};
      if (win == 4'b0110) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.fp    = 3'(i);
        end
        r.mc = r.mc + 4'd1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp_v);
    nchecks++;
    if (act != exp_v) begin
      nerrors++;
      $display("FAIL %s lat%0d cyc%0d: got %0d expected %0d", nm, k, cyc, act, exp_v);
    end
  endtask

  task automatic step(input logic s, input logic [W-1:0] d);
    @(negedge clk);
    start = s;
    din   = d;
    if (s) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc + 1 >= nf[k]) begin
          la[k] = cyc + 1;
          ld[k] = d;
          nf[k] = cyc + 1 + W + k + 3;
          if (k == 0) q0.push_back(ref_scan(d));
          else        q1.push_back(ref_scan(d));
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      la[k]   = -1000;
      held[k] = '0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, int'(busy_w[k]), 0);
      chk("rst_det_reset", k, int'(dr_w[k]), 1);
      chk("rst_done", k, int'(done_w[k]), 0);
      chk("rst_count", k, int'(mc_w[k]), 0);
      chk("rst_found", k, int'(found_w[k]), 0);
    end
    repeat (n - 1) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) nf[k] = cyc + 1;
  endtask

  task automatic mon(input int k);
    int   rel;
    logic edx;
    res_t e;
    bit   have;
    rel = cyc - la[k];
    edx = (rel >= 1 && rel <= W) ? ld[k][W-rel] : 1'b0;
    chk("busy", k, int'(busy_w[k]), int'(rel >= 0 && rel <= W + k + 1));
    chk("det_reset", k, int'(dr_w[k]), int'(rel == 0));
    chk("det_x", k, int'(dx_w[k]), int'(edx));
    chk("done", k, int'(done_w[k]), int'(rel == W + k + 1));
    if (done_w[k]) begin
      have = 1'b0;
      if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      chk("done_pending", k, int'(have), 1);
      if (have) begin
        chk("match_count", k, int'(mc_w[k]), int'(e.mc));
        chk("found", k, int'(found_w[k]), int'(e.found));
        chk("first_pos", k, int'(fp_w[k]), int'(e.fp));
        held[k] = e;
      end
    end else if (!busy_w[k]) begin
      chk("hold_count", k, int'(mc_w[k]), int'(held[k].mc));
      chk("hold_found", k, int'(found_w[k]), int'(held[k].found));
      chk("hold_first", k, int'(fp_w[k]), int'(held[k].fp));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      la[k]   = -1000;
      nf[k]   = 0;
      ld[k]   = '0;
      held[k] = '0;
    end

    do_reset(2);

    step(1'b1, 8'b0011_0110);
    repeat (15) step(1'b0, 8'h00);

    step(1'b1, 8'h00);
    repeat (15) step(1'b0, 8'h00);

    repeat (20) step(1'b1, 8'b0110_0110);
    repeat (15) step(1'b0, 8'h00);

    step(1'b1, 8'b0011_0110);
    repeat (3) step(1'b0, 8'b0011_0110);
    do_reset(2);
    step(1'b1, 8'b0011_0110);
    repeat (15) step(1'b0, 8'h00);

    repeat (40) begin
      logic [W-1:0] d;
      int hold_n;
      int gap_n;
      d      = W'($urandom_range(0, 255));
      hold_n = $urandom_range(1, 14);
      gap_n  = $urandom_range(0, 6);
      repeat (hold_n) step(1'b1, d);
      repeat (gap_n) step(1'b0, d);
    end

    repeat (20) step(1'b0, 8'h00);
    chk("pending_at_end", 0, q0.size(), 0);
    chk("pending_at_end", 1, q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
